multi_edge_detector: RTL and testbench

//  Multi-channel edge detector: synchroniser, debounce and per-channel mode.

---
 rtl/multi_edge_detector_if.sv | 25 ++
 rtl/multi_edge_detector.sv | 111 +++++++++++
 tb/tb_multi_edge_detector.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multi_edge_detector_if.sv
// Signal bundle between raw fault/shutdown pins and the multi-channel edge detector.
// The master side drives pins, modes and clears; the slave side is the detector.
interface multi_edge_detector_if #(
  parameter int CH = 4
) ();
  logic [CH-1:0]   sig_in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   level;
  logic [CH-1:0]   rise_pulse;
  logic [CH-1:0]   fall_pulse;
  logic [CH-1:0]   edge_pulse;
  logic [CH-1:0]   pending;
  logic            any_pending;

  modport master (
    output sig_in, mode, clr,
    input  level, rise_pulse, fall_pulse, edge_pulse, pending, any_pending
  );

  modport slave (
    input  sig_in, mode, clr,
    output level, rise_pulse, fall_pulse, edge_pulse, pending, any_pending
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Per-channel synchroniser, debounce filter and mode-qualified edge detection with
// sticky pending flags; an input already high at reset exit is absorbed silently.
module multi_edge_detector #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input logic                clk,
  input logic                rst,
  multi_edge_detector_if.slave bus
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  function automatic logic [CH-1:0] qualify(input logic [CH-1:0]   rise,
                                            input logic [CH-1:0]   fall,
                                            input logic [2*CH-1:0] mode);
    logic [CH-1:0] q;
    for (int i = 0; i < CH; i++)
      q[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);
    return q;
  endfunction

  logic [CH-1:0]    sync_p0 [SYNC_STAGES];
  logic [CH-1:0]    sync_out;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [CNT_W-1:0] cnt_p1 [CH];
  logic [CNT_W-1:0] cnt_nxt [CH];
  logic [CH-1:0]    level_p1, level_nxt;
  logic [CH-1:0]    rise_p1, rise_nxt;
  logic [CH-1:0]    fall_p1, fall_nxt;
  logic [CH-1:0]    edge_p1;
  logic [CH-1:0]    pending_p2;

  // Stage p0: synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
    end else begin
      sync_p0[0] <= bus.sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
    end
  end

  assign sync_out = sync_p0[SYNC_STAGES-1];

  // Arming waits one edge past the synchroniser depth so level captures the
  // settled pin value before the debounce filter starts looking for changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (arm_cnt == ARM_W'(SYNC_STAGES)) armed <= 1'b1;
      else                                arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  always_comb begin
    level_nxt = level_p1;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_nxt[i] = cnt_p1[i];
      if (!armed) begin
        level_nxt[i] = sync_out[i];
        cnt_nxt[i]   = '0;
      end else if (sync_out[i] == level_p1[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_p1[i] == CNT_W'(DB_CYCLES - 1)) begin
        level_nxt[i] = sync_out[i];
        cnt_nxt[i]   = '0;
        rise_nxt[i]  = sync_out[i];
        fall_nxt[i]  = ~sync_out[i];
      end else begin
        cnt_nxt[i] = cnt_p1[i] + CNT_W'(1);
      end
    end
  end

  // Stage p1: debounced level, counters and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) cnt_p1[i] <= '0;
      level_p1 <= '0;
      rise_p1  <= '0;
      fall_p1  <= '0;
      edge_p1  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) cnt_p1[i] <= cnt_nxt[i];
      level_p1 <= level_nxt;
      rise_p1  <= rise_nxt;
      fall_p1  <= fall_nxt;
      edge_p1  <= qualify(rise_nxt, fall_nxt, bus.mode);
    end
  end

  // Stage p2: sticky pending, a concurrent edge pulse beats clear
  always_ff @(posedge clk) begin
    if (rst) pending_p2 <= '0;
    else     pending_p2 <= edge_p1 | (pending_p2 & ~bus.clr);
  end

  assign bus.level       = level_p1;
  assign bus.rise_pulse  = rise_p1;
  assign bus.fall_pulse  = fall_p1;
  assign bus.edge_pulse  = edge_p1;
  assign bus.pending     = pending_p2;
  assign bus.any_pending = |pending_p2;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (CH=4, SYNC_STAGES=2, DB_CYCLES=4):
// pulse timing, glitch rejection, modes, pending set/clear and reset behaviour.
module tb_multi_edge_detector;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   rise_cnt [4];
  int   fall_cnt [4];
  int   edge_cnt [4];
  int   r0, f0, e0;

  multi_edge_detector_if #(.CH(4)) bus ();

  multi_edge_detector #(.CH(4), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 4; i++) begin
    rise_cnt[i] = 0; fall_cnt[i] = 0; edge_cnt[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.rise_pulse[i] === 1'b1) rise_cnt[i]++;
      if (bus.fall_pulse[i] === 1'b1) fall_cnt[i]++;
      if (bus.edge_pulse[i] === 1'b1) edge_cnt[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 32'h0);
    chk({tag, "_rise"},  32'(bus.rise_pulse), 32'h0);
    chk({tag, "_fall"},  32'(bus.fall_pulse), 32'h0);
    chk({tag, "_edge"},  32'(bus.edge_pulse), 32'h0);
    chk({tag, "_pend"},  32'(bus.pending), 32'h0);
    chk({tag, "_any"},   32'(bus.any_pending), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.sig_in = 4'h0;
    bus.clr    = 4'h0;
    bus.mode   = 8'b11_11_01_01;   // ch3 both, ch2 both, ch1 rise, ch0 rise
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(4);
    chk("armed_level", 32'(bus.level), 32'h0);

    // Test 1: rising edge on ch0, exact latency and one-cycle width
    bus.sig_in[0] = 1'b1;
    tick(5);
    chk("t1_rise_early", 32'(bus.rise_pulse[0]), 32'h0);
    chk("t1_level_early", 32'(bus.level[0]), 32'h0);
    tick(1);
    chk("t1_rise", 32'(bus.rise_pulse[0]), 32'h1);
    chk("t1_edge", 32'(bus.edge_pulse[0]), 32'h1);
    chk("t1_fall", 32'(bus.fall_pulse[0]), 32'h0);
    chk("t1_level", 32'(bus.level[0]), 32'h1);
    tick(1);
    chk("t1_rise_end", 32'(bus.rise_pulse[0]), 32'h0);
    chk("t1_edge_end", 32'(bus.edge_pulse[0]), 32'h0);
    chk("t1_pend", 32'(bus.pending[0]), 32'h1);
    chk("t1_any", 32'(bus.any_pending), 32'h1);
    bus.clr[0] = 1'b1;
    tick(1);
    bus.clr[0] = 1'b0;
    chk("t1_clr", 32'(bus.pending[0]), 32'h0);
    chk("t1_any_clr", 32'(bus.any_pending), 32'h0);
    tick(1);
    chk("t1_clr_again", 32'(bus.pending[0]), 32'h0);

    // Test 2: 3-cycle glitch rejected, 4-cycle pulse accepted
    r0 = rise_cnt[1]; f0 = fall_cnt[1];
    bus.sig_in[1] = 1'b1;
    tick(3);
    bus.sig_in[1] = 1'b0;
    tick(10);
    chk("t2_glitch_rise", 32'(rise_cnt[1] - r0), 32'h0);
    chk("t2_glitch_level", 32'(bus.level[1]), 32'h0);
    chk("t2_glitch_pend", 32'(bus.pending[1]), 32'h0);
    bus.sig_in[1] = 1'b1;
    tick(4);
    bus.sig_in[1] = 1'b0;
    tick(12);
    chk("t2_db4_rise", 32'(rise_cnt[1] - r0), 32'h1);
    chk("t2_db4_fall", 32'(fall_cnt[1] - f0), 32'h1);
    chk("t2_db4_pend", 32'(bus.pending[1]), 32'h1);
    chk("t2_db4_level", 32'(bus.level[1]), 32'h0);

    // Test 3: ch2 modes both, fall-only, off
    r0 = rise_cnt[2]; f0 = fall_cnt[2]; e0 = edge_cnt[2];
    bus.sig_in[2] = 1'b1;
    tick(10);
    chk("t3_level_hi", 32'(bus.level[2]), 32'h1);
    bus.sig_in[2] = 1'b0;
    tick(10);
    chk("t3_both_edges", 32'(edge_cnt[2] - e0), 32'h2);
    bus.mode[5:4] = 2'b10;
    e0 = edge_cnt[2];
    bus.sig_in[2] = 1'b1;
    tick(10);
    chk("t3_fall_mode_rise", 32'(edge_cnt[2] - e0), 32'h0);
    bus.sig_in[2] = 1'b0;
    tick(10);
    chk("t3_fall_mode", 32'(edge_cnt[2] - e0), 32'h1);
    bus.mode[5:4] = 2'b00;
    e0 = edge_cnt[2];
    bus.sig_in[2] = 1'b1;
    tick(10);
    chk("t3_off_level", 32'(bus.level[2]), 32'h1);
    bus.sig_in[2] = 1'b0;
    tick(10);
    chk("t3_off_edges", 32'(edge_cnt[2] - e0), 32'h0);
    chk("t3_rise_total", 32'(rise_cnt[2] - r0), 32'h3);
    chk("t3_fall_total", 32'(fall_cnt[2] - f0), 32'h3);
    bus.clr = 4'hF;
    tick(1);
    bus.clr = 4'h0;
    chk("t3_clear_all", 32'(bus.pending), 32'h0);

    // Test 4: clr in the same cycle as a new edge pulse, set wins
    bus.sig_in[3] = 1'b1;
    tick(10);
    chk("t4_pend_set", 32'(bus.pending[3]), 32'h1);
    bus.sig_in[3] = 1'b0;
    tick(5);
    chk("t4_edge_early", 32'(bus.edge_pulse[3]), 32'h0);
    tick(1);
    chk("t4_edge", 32'(bus.edge_pulse[3]), 32'h1);
    bus.clr[3] = 1'b1;
    tick(1);
    chk("t4_set_wins", 32'(bus.pending[3]), 32'h1);
    tick(1);
    bus.clr[3] = 1'b0;
    chk("t4_clr_alone", 32'(bus.pending[3]), 32'h0);

    // Test 5: inputs high through reset release
    rst = 1'b1;
    bus.sig_in = 4'hF;
    tick(3);
    chk_all_zero("t5_reset");
    r0 = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    e0 = edge_cnt[0] + edge_cnt[1] + edge_cnt[2] + edge_cnt[3];
    rst = 1'b0;
    tick(8);
    chk("t5_level", 32'(bus.level), 32'hF);
    chk("t5_pend", 32'(bus.pending), 32'h0);
    chk("t5_no_rise", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] - r0), 32'h0);
    chk("t5_no_edge", 32'(edge_cnt[0] + edge_cnt[1] + edge_cnt[2] + edge_cnt[3] - e0), 32'h0);

    // Test 6: reset in the middle of a debounce count
    rst = 1'b1;
    bus.sig_in = 4'h0;
    tick(3);
    rst = 1'b0;
    tick(6);
    chk("t6_level_lo", 32'(bus.level), 32'h0);
    bus.sig_in[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk_all_zero("t6_reset");
    r0 = rise_cnt[0];
    rst = 1'b0;
    tick(8);
    chk("t6_level", 32'(bus.level[0]), 32'h1);
    chk("t6_no_rise", 32'(rise_cnt[0] - r0), 32'h0);
    chk("t6_pend", 32'(bus.pending[0]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
